// File: rtl/rv32_pkg.sv
// Shared definitions for the RV32 pipeline.
//   - ctrl_mem bit positions
//   - write-back select encodings
//   - memory stage FSM state type
package rv32_pkg;
  localparam int MEM_READ  = 4;
  localparam int MEM_WRITE = 3;
  localparam int REG_WRITE = 2;

  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC4 = 2'b10;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} mem_state_t;
endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   i_load          : capture ctrl/rd/pc4/alu this edge; when low a bubble is
//                     inserted (ctrl cleared, data fields hold)
//   i_rdata_en      : capture load data this edge
//   i_ctrl..i_rdata : next values
//   o_ctrl..o_rdata : registered WB-stage values
module mem_wb_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load,
  input  logic        i_rdata_en,
  input  logic [2:0]  i_ctrl,
  input  logic [31:0] i_rd,
  input  logic [31:0] i_pc4,
  input  logic [31:0] i_alu,
  input  logic [31:0] i_rdata,
  output logic [2:0]  o_ctrl,
  output logic [31:0] o_rd,
  output logic [31:0] o_pc4,
  output logic [31:0] o_alu,
  output logic [31:0] o_rdata
);
  logic [2:0]  r_ctrl;
  logic [31:0] r_rd, r_pc4, r_alu, r_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl  <= '0;
      r_rd    <= '0;
      r_pc4   <= '0;
      r_alu   <= '0;
      r_rdata <= '0;
    end else begin
      if (i_load) begin
        r_ctrl <= i_ctrl;
        r_rd   <= i_rd;
        r_pc4  <= i_pc4;
        r_alu  <= i_alu;
      end else begin
        r_ctrl <= '0;
      end
      if (i_rdata_en) r_rdata <= i_rdata;
    end
  end

  assign o_ctrl  = r_ctrl;
  assign o_rd    = r_rd;
  assign o_pc4   = r_pc4;
  assign o_alu   = r_alu;
  assign o_rdata = r_rdata;
endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues word loads/stores over a req/ack port, stalls
// upstream while an access is outstanding, and feeds the MEM/WB register.
// Ports:
//   clk, reset                          : clock, synchronous active-high reset
//   ctrl_mem, rd_mem, pc4_mem,
//   alu_result, write_data1             : EX-stage outputs
//   ctrl_wb, rd_wb, pc4_wb,
//   alu_result_wb, read_data_wb         : registered MEM/WB outputs
//   stall                               : combinational upstream hold
//   misalign                            : one-cycle pulse after a misaligned access
//   dmem_req/we/addr/wdata              : registered memory request
//   dmem_rdata, dmem_ack                : memory response
module mem_stage
  import rv32_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [4:0]         ctrl_mem,
  input  logic [31:0]        rd_mem,
  input  logic [31:0]        pc4_mem,
  input  logic signed [31:0] alu_result,
  input  logic signed [31:0] write_data1,
  output logic [2:0]         ctrl_wb,
  output logic [31:0]        rd_wb,
  output logic [31:0]        pc4_wb,
  output logic [31:0]        alu_result_wb,
  output logic [31:0]        read_data_wb,
  output logic               stall,
  output logic               misalign,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [31:0]        dmem_addr,
  output logic [31:0]        dmem_wdata,
  input  logic [31:0]        dmem_rdata,
  input  logic               dmem_ack
);
  mem_state_t  r_state;
  logic        r_misalign, r_req, r_we;
  logic [31:0] r_addr, r_wdata;

  logic       w_mem_op, w_aligned, w_idle, w_wait;
  logic       w_start, w_misal, w_done, w_wb_load, w_rdata_en;
  logic [2:0] w_wb_ctrl;

  assign w_mem_op  = ctrl_mem[MEM_READ] | ctrl_mem[MEM_WRITE];
  assign w_aligned = (alu_result[1:0] == 2'b00);
  assign w_idle    = (r_state == IDLE);
  assign w_wait    = (r_state == WAIT);
  assign w_start   = w_idle & w_mem_op & w_aligned;
  assign w_misal   = w_idle & w_mem_op & ~w_aligned;
  assign w_done    = w_wait & dmem_ack;

  // Gated by reset so a reset landing mid-WAIT never holds upstream.
  assign stall = ~reset & (w_start | (w_wait & ~dmem_ack));

  // Non-memory and misaligned ops retire straight from IDLE; memory ops
  // retire on the ack edge. Everything else is a bubble.
  assign w_wb_load  = (w_idle & ~w_start) | w_done;
  assign w_wb_ctrl  = w_misal ? 3'b000 : ctrl_mem[2:0];
  // r_we already resolves read+write to a store.
  assign w_rdata_en = w_done & ~r_we;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_misalign <= 1'b0;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else begin
      r_misalign <= w_misal;
      case (r_state)
        IDLE: if (w_start) begin
          r_state <= WAIT;
          r_req   <= 1'b1;
          r_we    <= ctrl_mem[MEM_WRITE];
          r_addr  <= alu_result;
          r_wdata <= write_data1;
        end
        WAIT: if (dmem_ack) begin
          r_state <= IDLE;
          r_req   <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign misalign   = r_misalign;
  assign dmem_req   = r_req;
  assign dmem_we    = r_we;
  assign dmem_addr  = r_addr;
  assign dmem_wdata = r_wdata;

  mem_wb_reg u_mem_wb (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_wb_load),
    .i_rdata_en(w_rdata_en),
    .i_ctrl    (w_wb_ctrl),
    .i_rd      (rd_mem),
    .i_pc4     (pc4_mem),
    .i_alu     (alu_result),
    .i_rdata   (dmem_rdata),
    .o_ctrl    (ctrl_wb),
    .o_rd      (rd_wb),
    .o_pc4     (pc4_wb),
    .o_alu     (alu_result_wb),
    .o_rdata   (read_data_wb)
  );
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: single-cycle vector table plus hand-written
// multi-cycle load/store/reset sequences.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  ctrl_mem;
  logic [31:0] rd_mem, pc4_mem;
  logic signed [31:0] alu_result, write_data1;
  logic [2:0]  ctrl_wb;
  logic [31:0] rd_wb, pc4_wb, alu_result_wb, read_data_wb;
  logic        stall, misalign, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] exp_rdata;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .reset(reset), .ctrl_mem(ctrl_mem), .rd_mem(rd_mem),
    .pc4_mem(pc4_mem), .alu_result(alu_result), .write_data1(write_data1),
    .ctrl_wb(ctrl_wb), .rd_wb(rd_wb), .pc4_wb(pc4_wb),
    .alu_result_wb(alu_result_wb), .read_data_wb(read_data_wb),
    .stall(stall), .misalign(misalign), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
  );

  typedef struct {
    logic [4:0]  ctrl;
    logic [31:0] rd, pc4, alu, wd;
    logic        e_stall;
    logic [2:0]  e_ctrl_wb;
    logic        e_mis;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] c, input logic [31:0] rd, input logic [31:0] pc4,
                       input logic [31:0] alu, input logic [31:0] wd);
    ctrl_mem = c; rd_mem = rd; pc4_mem = pc4; alu_result = alu; write_data1 = wd;
  endtask

  // advance to 1 time unit past the next rising edge
  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    vt[0] = '{5'b00100, 32'd5,  32'h10, 32'h4000_0000, 32'h0,   1'b0, 3'b100, 1'b0};
    vt[1] = '{5'b00110, 32'd7,  32'h14, 32'h0000_1234, 32'h0,   1'b0, 3'b110, 1'b0};
    vt[2] = '{5'b10101, 32'd8,  32'h18, 32'h0000_0102, 32'h0,   1'b0, 3'b000, 1'b1};
    vt[3] = '{5'b01000, 32'd9,  32'h1C, 32'h0000_0203, 32'h55,  1'b0, 3'b000, 1'b1};
    vt[4] = '{5'b00000, 32'd10, 32'h20, 32'h0000_0000, 32'h0,   1'b0, 3'b000, 1'b0};
    vt[5] = '{5'b11100, 32'd11, 32'h24, 32'h0000_0301, 32'h66,  1'b0, 3'b000, 1'b1};
    vt[6] = '{5'b00010, 32'd12, 32'h28, 32'hFFFF_FFFC, 32'h0,   1'b0, 3'b010, 1'b0};

    // ---------- reset with random inputs ----------
    reset = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    drive(5'b10100, 32'h0, 32'h0, 32'h100, 32'h0);
    #1;
    for (int i = 0; i < 2; i++) begin
      drive(5'($urandom), $urandom, $urandom, $urandom, $urandom);
      dmem_ack = 1'($urandom); dmem_rdata = $urandom;
      #1 chk("rst_stall", {31'b0, stall}, 32'h0);
      tick();
    end
    chk("rst_ctrl_wb", {29'b0, ctrl_wb}, 32'h0);
    chk("rst_rd_wb", rd_wb, 32'h0);
    chk("rst_pc4_wb", pc4_wb, 32'h0);
    chk("rst_alu_wb", alu_result_wb, 32'h0);
    chk("rst_rdata_wb", read_data_wb, 32'h0);
    chk("rst_misalign", {31'b0, misalign}, 32'h0);
    chk("rst_req", {31'b0, dmem_req}, 32'h0);
    chk("rst_we", {31'b0, dmem_we}, 32'h0);
    chk("rst_addr", dmem_addr, 32'h0);
    chk("rst_wdata", dmem_wdata, 32'h0);
    reset = 1'b0; dmem_ack = 1'b0;
    drive(5'b00000, 32'h3, 32'h4, 32'h8, 32'h0);
    #1 chk("post_rst_stall", {31'b0, stall}, 32'h0);
    tick();
    chk("post_rst_ctrl_wb", {29'b0, ctrl_wb}, 32'h0);
    exp_rdata = 32'h0;

    // ---------- single-cycle vector table ----------
    foreach (vt[i]) begin
      drive(vt[i].ctrl, vt[i].rd, vt[i].pc4, vt[i].alu, vt[i].wd);
      #1 chk($sformatf("v%0d_stall", i), {31'b0, stall}, {31'b0, vt[i].e_stall});
      tick();
      chk($sformatf("v%0d_ctrl_wb", i), {29'b0, ctrl_wb}, {29'b0, vt[i].e_ctrl_wb});
      chk($sformatf("v%0d_rd_wb", i), rd_wb, vt[i].rd);
      chk($sformatf("v%0d_pc4_wb", i), pc4_wb, vt[i].pc4);
      chk($sformatf("v%0d_alu_wb", i), alu_result_wb, vt[i].alu);
      chk($sformatf("v%0d_rdata_wb", i), read_data_wb, exp_rdata);
      chk($sformatf("v%0d_misalign", i), {31'b0, misalign}, {31'b0, vt[i].e_mis});
      chk($sformatf("v%0d_req", i), {31'b0, dmem_req}, 32'h0);
    end

    // ---------- load, ack on 3rd WAIT cycle ----------
    drive(5'b10101, 32'd3, 32'h30, 32'h100, 32'h0);
    dmem_rdata = 32'hDEAD_BEEF;
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("ld_stall%0d", k), {31'b0, stall}, 32'h1);
      tick();
      chk($sformatf("ld_req%0d", k), {31'b0, dmem_req}, 32'h1);
      chk($sformatf("ld_addr%0d", k), dmem_addr, 32'h100);
      chk($sformatf("ld_we%0d", k), {31'b0, dmem_we}, 32'h0);
      chk($sformatf("ld_ctrl_wb%0d", k), {29'b0, ctrl_wb}, 32'h0);
    end
    dmem_ack = 1'b1;
    #1 chk("ld_ack_stall", {31'b0, stall}, 32'h0);
    tick();
    dmem_ack = 1'b0;
    exp_rdata = 32'hDEAD_BEEF;
    chk("ld_rdata_wb", read_data_wb, exp_rdata);
    chk("ld_ctrl_wb", {29'b0, ctrl_wb}, 32'h5);
    chk("ld_alu_wb", alu_result_wb, 32'h100);
    chk("ld_rd_wb", rd_wb, 32'd3);
    chk("ld_req_drop", {31'b0, dmem_req}, 32'h0);

    // ---------- store, ack on 1st WAIT cycle (ack also high in IDLE) ----------
    drive(5'b01000, 32'd4, 32'h34, 32'h200, -32'sd70);
    dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
    #1 chk("st_idle_stall", {31'b0, stall}, 32'h1);
    tick();
    chk("st_req", {31'b0, dmem_req}, 32'h1);
    chk("st_we", {31'b0, dmem_we}, 32'h1);
    chk("st_addr", dmem_addr, 32'h200);
    chk("st_wdata", dmem_wdata, 32'hFFFF_FFBA);
    #1 chk("st_ack_stall", {31'b0, stall}, 32'h0);
    tick();
    dmem_ack = 1'b0;
    chk("st_req_drop", {31'b0, dmem_req}, 32'h0);
    chk("st_rdata_hold", read_data_wb, exp_rdata);
    chk("st_ctrl_wb", {29'b0, ctrl_wb}, 32'h0);
    chk("st_alu_wb", alu_result_wb, 32'h200);

    // ---------- reset mid-WAIT ----------
    drive(5'b10101, 32'd6, 32'h40, 32'h400, 32'h0);
    tick();
    chk("mw_req", {31'b0, dmem_req}, 32'h1);
    reset = 1'b1;
    #1 chk("mw_rst_stall", {31'b0, stall}, 32'h0);
    tick();
    chk("mw_req_drop", {31'b0, dmem_req}, 32'h0);
    chk("mw_rdata_clr", read_data_wb, 32'h0);
    reset = 1'b0;
    exp_rdata = 32'h0;
    // IDLE after reset: a non-memory op must not stall
    drive(5'b00100, 32'd1, 32'h44, 32'h44, 32'h0);
    #1 chk("mw_idle_stall", {31'b0, stall}, 32'h0);
    tick();
    chk("mw_idle_ctrl_wb", {29'b0, ctrl_wb}, 32'h4);

    // ---------- back-to-back loads, each acked in 1st WAIT cycle ----------
    drive(5'b10101, 32'd13, 32'h50, 32'h500, 32'h0);
    #1 chk("bb_a_stall", {31'b0, stall}, 32'h1);
    tick();
    chk("bb_a_req", {31'b0, dmem_req}, 32'h1);
    dmem_ack = 1'b1; dmem_rdata = 32'h1111_1111;
    tick();
    chk("bb_a_rdata", read_data_wb, 32'h1111_1111);
    chk("bb_a_ctrl_wb", {29'b0, ctrl_wb}, 32'h5);
    chk("bb_gap_req", {31'b0, dmem_req}, 32'h0);
    dmem_ack = 1'b0;
    drive(5'b10101, 32'd14, 32'h54, 32'h504, 32'h0);
    #1 chk("bb_b_stall", {31'b0, stall}, 32'h1);
    tick();
    chk("bb_b_req", {31'b0, dmem_req}, 32'h1);
    chk("bb_b_addr", dmem_addr, 32'h504);
    chk("bb_b_ctrl_wb", {29'b0, ctrl_wb}, 32'h0);
    dmem_ack = 1'b1; dmem_rdata = 32'h2222_2222;
    tick();
    dmem_ack = 1'b0;
    chk("bb_b_rdata", read_data_wb, 32'h2222_2222);
    chk("bb_b_alu_wb", alu_result_wb, 32'h504);
    chk("bb_b_req_drop", {31'b0, dmem_req}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
